envelope_adsr: RTL

ENVELOPE_ADSR -- requirements
Module: envelope_adsr

---
 rtl/envelope_adsr.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/envelope_adsr.sv
// ADSR envelope generator: steps a gain register once per sample tick and
// scales offset-binary samples by it, producing a registered enveloped sample.
module envelope_adsr #(
  parameter int BIT_DEPTH = 8,
  parameter int ENV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 gate,
  input  logic [BIT_DEPTH-1:0] in_sample,
  input  logic [ENV_WIDTH-1:0] attack_step,
  input  logic [ENV_WIDTH-1:0] decay_step,
  input  logic [ENV_WIDTH-1:0] release_step,
  input  logic [ENV_WIDTH-1:0] sustain_level,
  output logic [BIT_DEPTH-1:0] out,
  output logic                 out_valid,
  output logic [2:0]           state,
  output logic                 busy
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam logic [ENV_WIDTH-1:0] ENV_MAX     = {ENV_WIDTH{1'b1}};
  localparam logic [BIT_DEPTH-1:0] SAMPLE_HALF = {1'b1, {(BIT_DEPTH-1){1'b0}}};
  localparam int                   PROD_W      = BIT_DEPTH + ENV_WIDTH + 1;

  logic [ENV_WIDTH-1:0] env;
  logic [ENV_WIDTH-1:0] env_next;
  logic [2:0]           state_next;

  // Step arithmetic carries one extra bit so overflow/borrow is visible.
  logic [ENV_WIDTH:0] env_add;
  logic [ENV_WIDTH:0] env_dec;
  logic [ENV_WIDTH:0] env_rel;
  logic               attack_full;
  logic               decay_floor;
  logic               release_floor;

  assign env_add = {1'b0, env} + {1'b0, attack_step};
  assign env_dec = {1'b0, env} - {1'b0, decay_step};
  assign env_rel = {1'b0, env} - {1'b0, release_step};

  assign attack_full   = (attack_step == '0) || (env_add >= {1'b0, ENV_MAX});
  assign decay_floor   = (decay_step == '0) || (env <= sustain_level) || env_dec[ENV_WIDTH] ||
                         (env_dec[ENV_WIDTH-1:0] <= sustain_level);
  assign release_floor = (release_step == '0) || env_rel[ENV_WIDTH] || (env_rel == '0);

  // A released gate overrides every held-note state's own transition.
  always_comb begin
    state_next = state;
    env_next   = env;
    case (state)
      ST_IDLE: begin
        if (gate) begin
          state_next = ST_ATTACK;
        end else begin
          env_next = '0;
        end
      end
      ST_ATTACK: begin
        if (!gate) begin
          state_next = ST_RELEASE;
        end else if (attack_full) begin
          env_next   = ENV_MAX;
          state_next = ST_DECAY;
        end else begin
          env_next = env_add[ENV_WIDTH-1:0];
        end
      end
      ST_DECAY: begin
        if (!gate) begin
          state_next = ST_RELEASE;
        end else if (decay_floor) begin
          env_next   = sustain_level;
          state_next = ST_SUSTAIN;
        end else begin
          env_next = env_dec[ENV_WIDTH-1:0];
        end
      end
      ST_SUSTAIN: begin
        if (!gate) begin
          state_next = ST_RELEASE;
        end else begin
          env_next = sustain_level;
        end
      end
      ST_RELEASE: begin
        if (gate) begin
          state_next = ST_ATTACK;
        end else if (release_floor) begin
          env_next   = '0;
          state_next = ST_IDLE;
        end else begin
          env_next = env_rel[ENV_WIDTH-1:0];
        end
      end
      default: begin
        env_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // Gain scaling around the silence midpoint; the arithmetic shift floors,
  // and the bits kept already hold the wrapped sum needed for SAMPLE_HALF + q.
  logic signed [BIT_DEPTH:0]  diff;
  logic signed [PROD_W-1:0]   prod;
  logic [BIT_DEPTH-1:0]       scaled;
  logic                       unused_prod_bits;

  assign diff = $signed({1'b0, in_sample}) - $signed({1'b0, SAMPLE_HALF});
  assign prod = PROD_W'(diff) * PROD_W'($signed({1'b0, env}));
  assign unused_prod_bits = ^{prod[ENV_WIDTH-1:0], prod[PROD_W-1]};

  always_comb begin
    if (env == ENV_MAX) begin
      scaled = in_sample;
    end else begin
      scaled = SAMPLE_HALF + prod[ENV_WIDTH +: BIT_DEPTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      env       <= '0;
      out       <= SAMPLE_HALF;
      out_valid <= 1'b0;
    end else begin
      out_valid <= sample_tick;
      if (sample_tick) begin
        state <= state_next;
        env   <= env_next;
        out   <= scaled;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
